// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell plus a carry flop, LSB first, one bit per clock.
// Latency: done pulses WIDTH cycles after the start-accepting edge; back-to-back ops every WIDTH+2 cycles.
// Backpressure: none; start is only honoured in IDLE and ignored while RUN or DONE.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // Counter must be able to represent WIDTH itself (value after the last RUN edge).
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             fa_sum;
  logic             fa_carry;

  // Single full-adder cell operating on the current operand LSBs and the carry flop.
  always_comb begin
    fa_sum   = a_q[0] ^ b_q[0] ^ carry_q;
    fa_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
  end

  // Next-state and datapath control; every register holds unless the state says otherwise.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Operands and carry-in are captured only here; later input changes are irrelevant.
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        // Sum bits enter from the MSB side so that after WIDTH shifts bit 0 sits at the LSB.
        sum_d   = {fa_sum, sum_q[WIDTH-1:1]};
        carry_d = fa_carry;
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          // cout only changes on the final bit so it stays stable outside RUN.
          cout_d  = fa_carry;
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Status flags are registered copies of the next state, keeping outputs flop-driven.
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed and random bench for serial_adder with a result scoreboard.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  int           n_chk;
  int           n_err;
  int           cyc;
  int           done_cnt;
  int           done_times[$];
  logic [W:0]   sb[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done) begin
      done_cnt++;
      done_times.push_back(cyc);
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        chk("result", {23'd0, cout, sum}, {23'd0, sb.pop_front()});
      end
    end
  end

  // Launch one addition and scramble the operand inputs right after acceptance.
  task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc);
    @(posedge clk); #1;
    start = 1'b1; a = ta; b = tb_; cin = tc;
    sb.push_back({1'b0, ta} + {1'b0, tb_} + {{W{1'b0}}, tc});
    @(posedge clk); #1;
    start = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk(tag, sb.size(), 0);
  endtask

  initial begin
    int d0;
    n_chk = 0; n_err = 0; cyc = 0; done_cnt = 0;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;

    // Reset state
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum",  sum, 0);
    chk("rst_cout", cout, 0);
    @(negedge clk); rst = 1'b0;

    // Case 1: busy for exactly WIDTH cycles, then one done cycle
    @(posedge clk); #1;
    start = 1'b1; a = 8'h3C; b = 8'h5A; cin = 1'b0;
    sb.push_back(9'h096);
    @(posedge clk); #1;
    start = 1'b0; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk("c1_busy_run", busy, 1);
      chk("c1_done_run", done, 0);
    end
    @(negedge clk);
    chk("c1_done_hi", done, 1);
    chk("c1_busy_done", busy, 0);
    chk("c1_sum", sum, 8'h96);
    @(negedge clk);
    chk("c1_done_lo", done, 0);
    chk("c1_sum_hold", sum, 8'h96);
    drain("c1_drain");

    // Case 2: overflow goes to cout only
    launch(8'hFF, 8'h01, 1'b0);
    drain("c2a_drain");
    chk("c2a_sum_hold", sum, 8'h00);
    chk("c2a_cout_hold", cout, 1);
    launch(8'hFF, 8'hFF, 1'b1);
    drain("c2b_drain");
    chk("c2b_sum_hold", sum, 8'hFF);

    // Case 3: start during RUN is ignored
    d0 = done_cnt;
    launch(8'h10, 8'h20, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; a = 8'hAA;
    @(posedge clk); #1;
    start = 1'b0;
    drain("c3_drain");
    repeat (15) @(negedge clk);
    chk("c3_one_done", done_cnt - d0, 1);
    chk("c3_sum", sum, 8'h30);

    // Case 4: asynchronous reset mid-RUN aborts without a done pulse
    d0 = done_cnt;
    launch(8'h77, 8'h11, 1'b1);
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    chk("c4_busy", busy, 0);
    chk("c4_done", done, 0);
    chk("c4_sum",  sum, 0);
    chk("c4_cout", cout, 0);
    chk("c4_idle", dut.state_q, 0);
    @(negedge clk); rst = 1'b0;
    repeat (15) @(negedge clk);
    chk("c4_no_done", done_cnt - d0, 0);
    launch(8'h01, 8'h01, 1'b0);
    drain("c4_new_drain");
    chk("c4_new_sum", sum, 8'h02);

    // Case 5: start held high for 30 cycles -> accepts every WIDTH+2 cycles
    repeat (3) @(posedge clk);
    done_times.delete();
    d0 = done_cnt;
    @(posedge clk); #1;
    start = 1'b1; a = 8'h81; b = 8'h82; cin = 1'b1;
    for (int i = 0; i < 3; i++) sb.push_back(9'h104);
    repeat (30) @(posedge clk);
    #1 start = 1'b0;
    drain("c5_drain");
    repeat (15) @(negedge clk);
    chk("c5_count", done_cnt - d0, 3);
    for (int i = 1; i < done_times.size(); i++)
      chk("c5_spacing", done_times[i] - done_times[i-1], W + 2);

    // Case 6: random operations
    for (int i = 0; i < 1000; i++) begin
      launch(W'($urandom), W'($urandom), 1'($urandom));
      drain("c6_drain");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The block SHALL have one parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide: reset, asynchronous and active-high.
REQ-004 Port start SHALL be an input, 1 bit wide: request to begin an addition.
REQ-005 Port a SHALL be an input, WIDTH bits wide: operand A.
REQ-006 Port b SHALL be an input, WIDTH bits wide: operand B.
REQ-007 Port cin SHALL be an input, 1 bit wide: carry-in.
REQ-008 Port busy SHALL be an output, 1 bit wide: an addition is in progress.
REQ-009 Port done SHALL be an output, 1 bit wide: one-cycle result-valid pulse.
REQ-010 Port sum SHALL be an output, WIDTH bits wide: result, A+B+cin modulo 2^WIDTH.
REQ-011 Port cout SHALL be an output, 1 bit wide: carry-out of the addition.

Function
REQ-012 The block SHALL add bit-serially, LSB first, one bit per clock, using a single full-adder cell and a carry flip-flop.
REQ-013 The block SHALL implement the FSM states IDLE, RUN and DONE.
REQ-014 In IDLE, start=1 sampled at a rising edge SHALL load a and b into shift registers, load the carry flop with cin, clear the bit counter, and move the FSM to RUN.
REQ-015 a, b and cin SHALL be sampled only at the accepting edge; later changes to them SHALL have no effect on the result.
REQ-016 In RUN, each rising edge SHALL add the current LSBs of A and B to the carry, shift the sum bit into the sum register from the MSB side, update the carry flop, shift A and B right, and increment the counter.
REQ-017 On the WIDTH-th RUN edge, the FSM SHALL move to DONE; sum and cout SHALL then hold the final result.
REQ-018 DONE SHALL last exactly one cycle, followed unconditionally by IDLE.
REQ-019 done SHALL be 1 only in DONE; it rises WIDTH cycles after the start-accepting edge.
REQ-020 busy SHALL be 1 exactly in RUN.
REQ-021 start SHALL be ignored in RUN and in DONE: no restart, no operand reload.
REQ-022 A start held high continuously SHALL begin a new addition at the first edge in IDLE after DONE, so back-to-back operations take WIDTH+2 cycles each.
REQ-023 sum and cout SHALL remain stable from DONE until the next accepted start; partial values during RUN are don't-care to consumers.
REQ-024 All outputs SHALL be driven directly from registers, with no combinational path from inputs to outputs.
REQ-025 The counter SHALL be ceil(log2(WIDTH+1)) bits wide.
REQ-026 Overflow SHALL appear only on cout; sum SHALL wrap modulo 2^WIDTH.

Reset
REQ-027 Asserting rst SHALL immediately, without waiting for clk, force: FSM=IDLE, busy=0, done=0, sum=0, cout=0, counter=0, carry flop=0, operand shift registers=0.
REQ-028 Reset during RUN or DONE SHALL abort the operation; no done pulse SHALL follow for the aborted operation.
REQ-029 After rst is released, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-030 Case 1: WIDTH=8, a=8'h3C, b=8'h5A, cin=0, start pulse -> busy for 8 cycles, then done=1 for one cycle with sum=8'h96, cout=0.
REQ-031 Case 2: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1; a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
REQ-032 Case 3: start a=8'h10, b=8'h20; pulse start again with a=8'hAA in cycle 3 of RUN -> that start is ignored; result sum=8'h30, cout=0, and exactly one done pulse.
REQ-033 Case 4: assert rst in cycle 4 of RUN -> outputs immediately 0 and FSM=IDLE, no done pulse; a new start with a=8'h01, b=8'h01 -> sum=8'h02.
REQ-034 Case 5: start held at 1 for 30 cycles -> done pulses spaced exactly WIDTH+2=10 cycles apart; start is never accepted in DONE.
REQ-035 Case 6: random self-check with at least 1000 operations against (a+b+cin), comparing {cout,sum} at each done pulse.
